// File: rtl/amm_block_master.sv
// rtl/amm_block_master.sv - Avalon-MM block master: incrementing-pattern writes, pipelined checksum reads
module amm_block_master #(
    parameter int ADDRESSWIDTH    = 28,
    parameter int DATAWIDTH       = 32,
    parameter int LENWIDTH        = 8,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [ADDRESSWIDTH-1:0]   cmd_addr,
    input  logic [LENWIDTH-1:0]       cmd_len,
    input  logic [DATAWIDTH-1:0]      cmd_seed,
    output logic [ADDRESSWIDTH-1:0]   avm_address,
    output logic                      avm_read,
    output logic                      avm_write,
    output logic [DATAWIDTH-1:0]      avm_writedata,
    output logic [DATAWIDTH/8-1:0]    avm_byteenable,
    input  logic                      avm_waitrequest,
    input  logic [DATAWIDTH-1:0]      avm_readdata,
    input  logic                      avm_readdatavalid,
    output logic                      busy,
    output logic                      done,
    output logic [DATAWIDTH-1:0]      checksum,
    output logic [DATAWIDTH-1:0]      last_data,
    output logic [LENWIDTH-1:0]       word_count
);
    localparam logic [ADDRESSWIDTH-1:0] ADDR_STEP = ADDRESSWIDTH'(DATAWIDTH / 8);
    localparam logic [3:0]              MAX_OUT   = 4'(MAX_OUTSTANDING);
    localparam logic [LENWIDTH-1:0]     LEN_ONE   = LENWIDTH'(1);
    localparam logic [DATAWIDTH-1:0]    DATA_ONE  = DATAWIDTH'(1);

    typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_FINISH} state_t;

    state_t                   state_q, state_d;
    logic [LENWIDTH-1:0]      len_q, len_d;
    logic [LENWIDTH-1:0]      issued_q, issued_d;
    logic [3:0]               outstanding_q, outstanding_d;
    logic                     cmd_ready_q, cmd_ready_d;
    logic                     avm_read_q, avm_read_d;
    logic                     avm_write_q, avm_write_d;
    logic [ADDRESSWIDTH-1:0]  avm_address_q, avm_address_d;
    logic [DATAWIDTH-1:0]     avm_writedata_q, avm_writedata_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic [DATAWIDTH-1:0]     checksum_q, checksum_d;
    logic [DATAWIDTH-1:0]     last_data_q, last_data_d;
    logic [LENWIDTH-1:0]      word_count_q, word_count_d;

    logic                     issue, beat, rvalid;
    logic [LENWIDTH-1:0]      issued_n, word_count_n;
    logic [3:0]               outstanding_n;

    always_comb begin
        state_d         = state_q;
        len_d           = len_q;
        issued_d        = issued_q;
        outstanding_d   = outstanding_q;
        cmd_ready_d     = cmd_ready_q;
        avm_read_d      = avm_read_q;
        avm_write_d     = avm_write_q;
        avm_address_d   = avm_address_q;
        avm_writedata_d = avm_writedata_q;
        busy_d          = busy_q;
        done_d          = 1'b0;
        checksum_d      = checksum_q;
        last_data_d     = last_data_q;
        word_count_d    = word_count_q;

        issue  = avm_read_q & ~avm_waitrequest;
        beat   = avm_write_q & ~avm_waitrequest;
        // Data is only taken while a read phase still expects returns.
        rvalid = avm_readdatavalid & ((state_q == S_READ) | (state_q == S_DRAIN))
                 & (outstanding_q != 4'd0);
        issued_n      = issued_q + (issue ? LEN_ONE : '0);
        outstanding_n = outstanding_q + {3'b000, issue} - {3'b000, rvalid};
        word_count_n  = word_count_q + (rvalid ? LEN_ONE : '0);

        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    len_d           = cmd_len;
                    issued_d        = '0;
                    outstanding_d   = '0;
                    checksum_d      = '0;
                    word_count_d    = '0;
                    avm_address_d   = cmd_addr;
                    avm_writedata_d = cmd_seed;
                    busy_d          = 1'b1;
                    cmd_ready_d     = 1'b0;
                    if (cmd_len == '0) begin
                        state_d = S_FINISH;
                        done_d  = 1'b1;
                    end else if (cmd_write) begin
                        state_d     = S_WRITE;
                        avm_write_d = 1'b1;
                    end else begin
                        state_d    = S_READ;
                        avm_read_d = 1'b1;
                    end
                end
            end
            S_WRITE: begin
                if (beat) begin
                    word_count_d = word_count_q + LEN_ONE;
                    last_data_d  = avm_writedata_q;
                    if (word_count_q + LEN_ONE == len_q) begin
                        avm_write_d = 1'b0;
                        state_d     = S_FINISH;
                        done_d      = 1'b1;
                    end else begin
                        avm_address_d   = avm_address_q + ADDR_STEP;
                        avm_writedata_d = avm_writedata_q + DATA_ONE;
                    end
                end
            end
            S_READ, S_DRAIN: begin
                issued_d      = issued_n;
                outstanding_d = outstanding_n;
                word_count_d  = word_count_n;
                if (issue) avm_address_d = avm_address_q + ADDR_STEP;
                if (rvalid) begin
                    checksum_d  = checksum_q + avm_readdata;
                    last_data_d = avm_readdata;
                end
                avm_read_d = (state_q == S_READ) && (issued_n < len_q) && (outstanding_n < MAX_OUT);
                if (issued_n == len_q) begin
                    if (word_count_n == len_q) begin
                        state_d = S_FINISH;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_FINISH: begin
                busy_d      = 1'b0;
                cmd_ready_d = 1'b1;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= S_IDLE;
            len_q           <= '0;
            issued_q        <= '0;
            outstanding_q   <= '0;
            cmd_ready_q     <= 1'b1;
            avm_read_q      <= 1'b0;
            avm_write_q     <= 1'b0;
            avm_address_q   <= '0;
            avm_writedata_q <= '0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            checksum_q      <= '0;
            last_data_q     <= '0;
            word_count_q    <= '0;
        end else begin
            state_q         <= state_d;
            len_q           <= len_d;
            issued_q        <= issued_d;
            outstanding_q   <= outstanding_d;
            cmd_ready_q     <= cmd_ready_d;
            avm_read_q      <= avm_read_d;
            avm_write_q     <= avm_write_d;
            avm_address_q   <= avm_address_d;
            avm_writedata_q <= avm_writedata_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
            checksum_q      <= checksum_d;
            last_data_q     <= last_data_d;
            word_count_q    <= word_count_d;
        end
    end

    assign cmd_ready      = cmd_ready_q;
    assign avm_read       = avm_read_q;
    assign avm_write      = avm_write_q;
    assign avm_address    = avm_address_q;
    assign avm_writedata  = avm_writedata_q;
    assign avm_byteenable = '1;
    assign busy           = busy_q;
    assign done           = done_q;
    assign checksum       = checksum_q;
    assign last_data      = last_data_q;
    assign word_count     = word_count_q;
endmodule
